multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath enables and selects, including the shared single-port memory request. Memory uses a request/ready handshake with a bounded wait. The block sits beside the register file, ALU and memory port. It replaces per-instruction combinational control with a state machine.

---
 rtl/core_pkg.sv | 42 ++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_sequencer.sv | 151 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcode classes,
// sequencer states and datapath select encodings.
package core_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_FAULT
   } state_t;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JAL    = 2'b10;
   localparam logic [1:0] PC_JALR   = 2'b11;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   localparam logic [1:0] JUMP_NONE = 2'b00;
   localparam logic [1:0] JUMP_JALR = 2'b01;
   localparam logic [1:0] JUMP_JAL  = 2'b10;

   // True for every opcode class the sequencer knows how to step through.
   function automatic logic op_known(input logic [6:0] op);
      return (op == OP_R)      || (op == OP_I)   || (op == OP_LOAD) ||
             (op == OP_STORE)  || (op == OP_BRANCH) ||
             (op == OP_JAL)    || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unanswered memory-request cycles; expired flags the
// cycle in which the count has reached WAIT_LIMIT and the request is still
// unanswered.
module mem_wait_timer #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

   logic [CW-1:0] count_q, count_d;

   assign expired = count_en && (count_q == LIMIT);

   // Next count: clear wins; otherwise advance on each waiting cycle below the limit.
   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (count_en && !expired)
         count_d = count_q + 1'b1;
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I instruction sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath enables.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | instruction read from memory at PC, IR loaded on ready
// S_DECODE | opcode latched into op_q and classified
// S_EXEC   | ALU operation; branches retire here
// S_MEM    | data load/store at ALU address; stores retire here
// S_WB     | register writeback and PC update
// S_FAULT  | illegal opcode or memory timeout; held until reset
module multicycle_sequencer
   import core_pkg::*;
#(
   parameter int WAIT_LIMIT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_is_fetch,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic [1:0] jump,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       fault
);

   state_t     state_q, state_d;
   logic [6:0] op_q, op_d;
   logic       wait_en, wait_expired;

   // Only FETCH and MEM hold a memory request open; those are the waiting cycles.
   assign wait_en = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

   mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_d != state_q),
      .count_en (wait_en),
      .expired  (wait_expired)
   );

   // Next-state and opcode latch; a ready response beats the timeout.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)         state_d = S_DECODE;
            else if (wait_expired) state_d = S_FAULT;
         end
         S_DECODE: begin
            op_d    = opcode;
            state_d = op_known(opcode) ? S_EXEC : S_FAULT;
         end
         S_EXEC: begin
            if (op_q == OP_BRANCH)                           state_d = S_FETCH;
            else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) state_d = S_MEM;
            else                                              state_d = S_WB;
         end
         S_MEM: begin
            if (mem_ready)         state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
            else if (wait_expired) state_d = S_FAULT;
         end
         S_WB:    state_d = S_FETCH;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   // State and latched opcode registers; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Datapath controls decoded from state and op_q; all forced low during reset.
   always_comb begin
      mem_req      = 1'b0;
      mem_is_fetch = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = PC_PLUS4;
      alu_op       = ALU_ADD;
      alu_src      = 1'b0;
      jump         = JUMP_NONE;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      instr_done   = 1'b0;
      fault        = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req      = 1'b1;
               mem_is_fetch = 1'b1;
               ir_write     = mem_ready;
            end
            S_EXEC: begin
               alu_src = (op_q == OP_I) || (op_q == OP_LOAD) ||
                         (op_q == OP_STORE) || (op_q == OP_JALR);
               if ((op_q == OP_R) || (op_q == OP_I)) alu_op = ALU_FUNCT;
               else if (op_q == OP_BRANCH)            alu_op = ALU_BRANCH;
               if (op_q == OP_BRANCH) begin
                  pc_write   = 1'b1;
                  pc_sel     = branch_taken ? PC_BRANCH : PC_PLUS4;
                  instr_done = 1'b1;
               end
            end
            S_MEM: begin
               mem_req   = 1'b1;
               mem_write = (op_q == OP_STORE);
               if (mem_ready && (op_q == OP_STORE)) begin
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               pc_write   = 1'b1;
               instr_done = 1'b1;
               mem_to_reg = (op_q == OP_LOAD);
               if (op_q == OP_JAL) begin
                  jump   = JUMP_JAL;
                  pc_sel = PC_JAL;
               end else if (op_q == OP_JALR) begin
                  jump   = JUMP_JALR;
                  pc_sel = PC_JALR;
               end
            end
            S_FAULT: fault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: each issued instruction pushes
// its expected retirement (or fault) record; a monitor pops and compares.
module tb_multicycle_sequencer;

   localparam int WL = 3;

   localparam logic [6:0] T_R      = 7'b0110011;
   localparam logic [6:0] T_I      = 7'b0010011;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_JALR   = 7'b1100111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = '0;
   logic       branch_taken = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_is_fetch, mem_write, ir_write, pc_write;
   logic [1:0] pc_sel, alu_op, jump;
   logic       alu_src, mem_to_reg, reg_write, instr_done, fault;

   multicycle_sequencer #(.WAIT_LIMIT(WL)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_is_fetch(mem_is_fetch),
      .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
      .pc_sel(pc_sel), .alu_op(alu_op), .alu_src(alu_src), .jump(jump),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .instr_done(instr_done), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_fault;
      int cyc;
      int exec_cyc;
      int pc_sel;
      int jump;
      int alu_op;
      int alu_src;
      int mem_to_reg;
      int reg_write;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         fwait = 0;
   int         mwait = 0;
   logic [6:0] legal_ops [7] = '{T_R, T_I, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR};

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycle counts and controls from instruction class rules.
   function automatic exp_t model(input logic [6:0] op, input bit bt, input int fw, input int mw);
      exp_t e;
      bit   legal;
      bit   is_mem;
      int   base;
      e = '{default: 0};
      legal = 0;
      foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1;
      is_mem = (op == T_LOAD) || (op == T_STORE);
      e.exec_cyc = fw + 3;
      base = 4;
      if (fw > WL) begin
         e.is_fault = 1; e.cyc = WL + 2; e.exec_cyc = -1;
      end else if (!legal) begin
         e.is_fault = 1; e.cyc = fw + 3; e.exec_cyc = -1;
      end else begin
         case (op)
            T_R:      begin e.alu_op = 2; e.reg_write = 1; end
            T_I:      begin e.alu_op = 2; e.alu_src = 1; e.reg_write = 1; end
            T_LOAD:   begin e.alu_src = 1; e.reg_write = 1; e.mem_to_reg = 1; base = 5 + mw; end
            T_STORE:  begin e.alu_src = 1; base = 4 + mw; end
            T_BRANCH: begin e.alu_op = 1; e.pc_sel = bt ? 1 : 0; base = 3; end
            T_JAL:    begin e.jump = 2; e.pc_sel = 2; e.reg_write = 1; end
            default:  begin e.alu_src = 1; e.jump = 1; e.pc_sel = 3; e.reg_write = 1; end
         endcase
         e.cyc = base + fw;
         if (is_mem && mw > WL) begin
            e.is_fault = 1; e.cyc = fw + WL + 5;
         end
      end
      return e;
   endfunction

   // Memory responder: answers each request phase after the programmed wait count.
   initial begin
      int n = 0;
      int w;
      bit prev_req = 0, prev_fetch = 0;
      forever begin
         @(negedge clk); #1;
         if (mem_req && (!prev_req || mem_is_fetch != prev_fetch)) n = 0;
         w = mem_is_fetch ? fwait : mwait;
         if (mem_req) begin
            mem_ready = (n >= w);
            n++;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         prev_req = mem_req;
         prev_fetch = mem_is_fetch;
      end
   end

   // Monitor: per-cycle invariants plus scoreboard pops on retire/fault.
   initial begin
      bit   in_instr = 0, fault_seen = 0, rst_prev = 1, exp_fetch = 0;
      int   cyc = 0;
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            check("reset_outputs_zero", int'({mem_req, mem_is_fetch, mem_write, ir_write,
                  pc_write, pc_sel, alu_op, alu_src, jump, mem_to_reg, reg_write,
                  instr_done, fault}), 0);
            in_instr = 0; fault_seen = 0; exp_fetch = 0;
         end else begin
            if (rst_prev) check("fetch_after_reset", int'(mem_req && mem_is_fetch), 1);
            if (exp_fetch) begin
               check("fetch_after_retire", int'(mem_req && mem_is_fetch), 1);
               exp_fetch = 0;
            end
            if (!in_instr && mem_req && mem_is_fetch && !fault) begin
               in_instr = 1; cyc = 0;
            end
            if (in_instr) cyc++;
            if (mem_req && mem_is_fetch) check("ir_write_on_ready", int'(ir_write), int'(mem_ready));
            check("reg_write_only_at_retire", int'(reg_write & ~instr_done), 0);
            if (in_instr && exp_q.size() > 0) begin
               if (cyc == exp_q[0].exec_cyc) begin
                  check("exec_alu_src", int'(alu_src), exp_q[0].alu_src);
                  check("exec_alu_op", int'(alu_op), exp_q[0].alu_op);
               end else begin
                  check("alu_quiet_outside_exec", int'({alu_src, alu_op}), 0);
               end
            end
            if (instr_done) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_retire: got instr_done=1 expected none at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("retire_not_fault", 0, int'(e.is_fault));
                  check("retire_cycles", cyc, e.cyc);
                  check("retire_pc_sel", int'(pc_sel), e.pc_sel);
                  check("retire_jump", int'(jump), e.jump);
                  check("retire_mem_to_reg", int'(mem_to_reg), e.mem_to_reg);
                  check("retire_reg_write", int'(reg_write), e.reg_write);
                  check("retire_pc_write", int'(pc_write), 1);
               end
               in_instr = 0; exp_fetch = 1;
            end
            if (fault && !fault_seen) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_fault: got fault=1 expected none at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("fault_expected", 1, int'(e.is_fault));
                  check("fault_cycle", cyc, e.cyc);
               end
               fault_seen = 1; in_instr = 0;
            end
            if (fault) check("fault_outputs_quiet", int'({mem_req, mem_write, ir_write,
                  pc_write, reg_write, instr_done, jump, pc_sel}), 0);
         end
         rst_prev = rst;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_instr(input logic [6:0] op, input bit bt, input int fw, input int mw);
      bit done = 0, flt = 0;
      opcode = op; branch_taken = bt; fwait = fw; mwait = mw;
      exp_q.push_back(model(op, bt, fw, mw));
      for (int i = 0; i < 100 && !done && !flt; i++) begin
         @(negedge clk); #3;
         if (instr_done) done = 1;
         if (fault) flt = 1;
      end
      if (!done && !flt) begin
         checks++; errors++;
         $display("FAIL instr_timeout: got no retire/fault expected one for op=%b", op);
         exp_q.delete();
         do_reset();
      end else if (flt) begin
         for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            check("fault_sticky", int'(fault), 1);
         end
         do_reset();
      end
   endtask

   task automatic reset_mid_store();
      bit found = 0;
      opcode = T_STORE; branch_taken = 0; fwait = 0; mwait = 2;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk); #3;
         if (mem_req && !mem_is_fetch) found = 1;
      end
      check("store_reaches_mem", int'(found), 1);
      rst = 1'b1; #1;
      check("mem_write_in_reset", int'(mem_write), 0);
      check("instr_done_in_reset", int'(instr_done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [6:0] op;
      int fw, mw;
      do_reset();
      run_instr(T_R, 0, 0, 0);
      run_instr(T_LOAD, 0, 3, 3);
      run_instr(T_BRANCH, 1, 0, 0);
      run_instr(T_BRANCH, 0, 0, 0);
      run_instr(T_JALR, 0, 0, 0);
      run_instr(T_JAL, 0, 1, 0);
      run_instr(T_STORE, 0, 0, 2);
      run_instr(7'b0000000, 0, 0, 0);
      run_instr(T_R, 0, WL + 1, 0);
      run_instr(T_R, 0, WL, 0);
      run_instr(T_STORE, 0, 0, WL + 1);
      reset_mid_store();
      run_instr(T_I, 0, 0, 0);
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 6)];
         else op = 7'($urandom);
         fw = ($urandom_range(0, 19) == 0) ? WL + 1 : int'($urandom_range(0, WL));
         mw = ($urandom_range(0, 19) == 0) ? WL + 1 : int'($urandom_range(0, WL));
         run_instr(op, 1'($urandom_range(0, 1)), fw, mw);
      end
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
